// File: rtl/control_unit_if.sv
// control_unit_if: control-unit <-> datapath bundle.
//   ir, con_ff : datapath -> control (instruction register, branch condition ff)
//   all others : control -> datapath one-clk strobes (bus drivers, memory/PC control,
//                one-hot ALU op, register select/enable, register loads, CON ff clear)
//   master: control unit side, slave: datapath side.
interface control_unit_if #(
   parameter int unsigned IR_W = 32
);
   logic [IR_W-1:0] ir;
   logic            con_ff;

   logic CON_RESET;
   logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout;
   logic Read, read_mem, write_mem, IncPC, PCSave;
   logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
   logic Gra, Grb, Grc, Rin, Rout, BAout;
   logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;

   modport master (
      input  ir, con_ff,
      output CON_RESET,
      output HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout,
      output Read, read_mem, write_mem, IncPC, PCSave,
      output AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
      output Gra, Grb, Grc, Rin, Rout, BAout,
      output HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin
   );

   modport slave (
      output ir, con_ff,
      input  CON_RESET,
      input  HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout,
      input  Read, read_mem, write_mem, IncPC, PCSave,
      input  AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
      input  Gra, Grb, Grc, Rin, Rout, BAout,
      input  HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin
   );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the 32-bit datapath.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset; forces RST from any state
//   stop  : level; go to HALT at the end of the current instruction
//   run   : 1 while sequencing, 0 in RST/HALT
//   bus   : control_unit_if.master (ir/con_ff in, all datapath strobes out)
// Fetch is T0-T2, decode of ir[OP_LSB+4:OP_LSB] from T2 on; every strobe is a one-clk decode of
// the registered step. The nop/halt exit out of T2 relies on the datapath presenting the fetched
// word on ir by the end of T2.
module control_unit #(
   parameter int unsigned IR_W   = 32,
   parameter int unsigned OP_LSB = 27
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           stop,
   output logic           run,
   control_unit_if.master bus
);

   if (OP_LSB + 5 > IR_W) begin : g_bad_params
      $error("opcode field does not fit in IR");
   end

   typedef enum logic [3:0] {
      StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StRst, StHalt
   } state_e;

   typedef enum logic [3:0] {
      ClsAlu, ClsImm, ClsMulDiv, ClsUnary, ClsLdi, ClsLd, ClsSt, ClsBr,
      ClsJr, ClsJal, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop, ClsHalt
   } cls_e;

   typedef enum logic [3:0] {
      AluAdd, AluSub, AluAnd, AluOr, AluShr, AluShra, AluShl, AluRor, AluRol,
      AluMul, AluDiv, AluNeg, AluNot
   } alu_e;

   state_e     state_q, state_d, last_step;
   cls_e       cls;
   alu_e       alu;
   logic       alu_en;
   logic [4:0] opcode;

   assign opcode = bus.ir[OP_LSB +: 5];

   // Instruction class and the ALU function it uses (address arithmetic defaults to ADD).
   always_comb begin
      cls = ClsNop;
      alu = AluAdd;
      unique case (opcode)
         5'd0:  cls = ClsLd;
         5'd1:  cls = ClsLdi;
         5'd2:  cls = ClsSt;
         5'd3:  begin cls = ClsAlu;    alu = AluAdd;  end
         5'd4:  begin cls = ClsAlu;    alu = AluSub;  end
         5'd5:  begin cls = ClsAlu;    alu = AluAnd;  end
         5'd6:  begin cls = ClsAlu;    alu = AluOr;   end
         5'd7:  begin cls = ClsAlu;    alu = AluShr;  end
         5'd8:  begin cls = ClsAlu;    alu = AluShra; end
         5'd9:  begin cls = ClsAlu;    alu = AluShl;  end
         5'd10: begin cls = ClsAlu;    alu = AluRor;  end
         5'd11: begin cls = ClsAlu;    alu = AluRol;  end
         5'd12: begin cls = ClsImm;    alu = AluAdd;  end
         5'd13: begin cls = ClsImm;    alu = AluAnd;  end
         5'd14: begin cls = ClsImm;    alu = AluOr;   end
         5'd15: begin cls = ClsMulDiv; alu = AluDiv;  end
         5'd16: begin cls = ClsMulDiv; alu = AluMul;  end
         5'd17: begin cls = ClsUnary;  alu = AluNeg;  end
         5'd18: begin cls = ClsUnary;  alu = AluNot;  end
         5'd19: cls = ClsBr;
         5'd20: cls = ClsJr;
         5'd21: cls = ClsJal;
         5'd22: cls = ClsIn;
         5'd23: cls = ClsOut;
         5'd24: cls = ClsMfhi;
         5'd25: cls = ClsMflo;
         5'd27: cls = ClsHalt;
         default: cls = ClsNop;  // nop and the undefined opcodes
      endcase
   end

   always_comb begin
      unique case (cls)
         ClsAlu, ClsImm, ClsLdi:                     last_step = StT5;
         ClsMulDiv, ClsBr:                           last_step = StT6;
         ClsLd, ClsSt:                               last_step = StT7;
         ClsUnary, ClsJal:                           last_step = StT4;
         ClsJr, ClsIn, ClsOut, ClsMfhi, ClsMflo:     last_step = StT3;
         default:                                    last_step = StT2;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= StRst;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRst:  state_d = StT0;
         StHalt: state_d = StHalt;
         StT0:   state_d = StT1;
         StT1:   state_d = StT2;
         default: begin
            if (state_q == StT2 && cls == ClsHalt) state_d = StHalt;
            else if (state_q == last_step)         state_d = stop ? StHalt : StT0;
            else                                   state_d = state_e'(state_q + 4'd1);
         end
      endcase
   end

   always_comb begin
      run = 1'b0;      alu_en = 1'b0;
      bus.CON_RESET = 1'b0;
      bus.HIout = 1'b0;  bus.LOout = 1'b0;  bus.Zhighout = 1'b0; bus.Zlowout = 1'b0;
      bus.PCout = 1'b0;  bus.MDRout = 1'b0; bus.INout = 1'b0;    bus.Cout = 1'b0;
      bus.Read = 1'b0;   bus.read_mem = 1'b0; bus.write_mem = 1'b0;
      bus.IncPC = 1'b0;  bus.PCSave = 1'b0;
      bus.AND = 1'b0;  bus.OR = 1'b0;   bus.ADD = 1'b0; bus.SUB = 1'b0;  bus.MUL = 1'b0;
      bus.DIV = 1'b0;  bus.SHR = 1'b0;  bus.SHRA = 1'b0; bus.SHL = 1'b0; bus.ROR = 1'b0;
      bus.ROL = 1'b0;  bus.NEG = 1'b0;  bus.NOT = 1'b0;
      bus.Gra = 1'b0;  bus.Grb = 1'b0;  bus.Grc = 1'b0; bus.Rin = 1'b0;  bus.Rout = 1'b0;
      bus.BAout = 1'b0;
      bus.HIin = 1'b0; bus.LOin = 1'b0; bus.PCin = 1'b0; bus.IRin = 1'b0; bus.Zin = 1'b0;
      bus.Yin = 1'b0;  bus.MARin = 1'b0; bus.MDRin = 1'b0; bus.CONin = 1'b0;
      bus.OUT_Portin = 1'b0;

      if (state_q != StRst && state_q != StHalt) run = 1'b1;

      unique case (state_q)
         StRst: bus.CON_RESET = 1'b1;
         StT0:  begin bus.IncPC = 1'b1; bus.MARin = 1'b1; bus.PCin = 1'b1; end
         StT1:  begin bus.Read = 1'b1; bus.read_mem = 1'b1; bus.MDRin = 1'b1; end
         StT2:  begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
         StT3: begin
            unique case (cls)
               ClsAlu, ClsImm: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
               ClsMulDiv:      begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
               ClsUnary: begin bus.Grb = 1'b1; bus.Rout = 1'b1; alu_en = 1'b1; bus.Zin = 1'b1; end
               ClsLdi, ClsLd, ClsSt: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
               ClsBr:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
               ClsJr:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
               ClsJal:  bus.PCSave = 1'b1;
               ClsIn:   begin bus.INout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
               ClsOut:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OUT_Portin = 1'b1; end
               ClsMfhi: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
               ClsMflo: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
               default: ;
            endcase
         end
         StT4: begin
            unique case (cls)
               ClsAlu:    begin bus.Grc = 1'b1; bus.Rout = 1'b1; alu_en = 1'b1; bus.Zin = 1'b1; end
               ClsMulDiv: begin bus.Grb = 1'b1; bus.Rout = 1'b1; alu_en = 1'b1; bus.Zin = 1'b1; end
               ClsImm, ClsLdi, ClsLd, ClsSt: begin bus.Cout = 1'b1; alu_en = 1'b1; bus.Zin = 1'b1; end
               ClsUnary: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
               ClsBr:    begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
               ClsJal:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
               default: ;
            endcase
         end
         StT5: begin
            unique case (cls)
               ClsAlu, ClsImm, ClsLdi: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
               ClsMulDiv:    begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
               ClsLd, ClsSt: begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
               ClsBr:        begin bus.Cout = 1'b1; alu_en = 1'b1; bus.Zin = 1'b1; end
               default: ;
            endcase
         end
         StT6: begin
            unique case (cls)
               ClsMulDiv: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
               ClsLd:     begin bus.Read = 1'b1; bus.read_mem = 1'b1; bus.MDRin = 1'b1; end
               ClsSt:     begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
               // Branch target only reaches the PC when the condition holds.
               ClsBr:     begin bus.Zlowout = bus.con_ff; bus.PCin = bus.con_ff; end
               default: ;
            endcase
         end
         StT7: begin
            unique case (cls)
               ClsLd:   begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
               ClsSt:   bus.write_mem = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase

      // Single decoder keeps the ALU op strobes one-hot.
      if (alu_en) begin
         unique case (alu)
            AluAdd:  bus.ADD  = 1'b1;
            AluSub:  bus.SUB  = 1'b1;
            AluAnd:  bus.AND  = 1'b1;
            AluOr:   bus.OR   = 1'b1;
            AluShr:  bus.SHR  = 1'b1;
            AluShra: bus.SHRA = 1'b1;
            AluShl:  bus.SHL  = 1'b1;
            AluRor:  bus.ROR  = 1'b1;
            AluRol:  bus.ROL  = 1'b1;
            AluMul:  bus.MUL  = 1'b1;
            AluDiv:  bus.DIV  = 1'b1;
            AluNeg:  bus.NEG  = 1'b1;
            AluNot:  bus.NOT  = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vectors for control_unit; every step's full strobe word (plus run)
// is compared against a hand-built expected word.
module tb_control_unit;

   logic clk = 1'b0;
   logic reset, stop, run;
   int   n_vec = 0;
   int   n_err = 0;

   control_unit_if #(.IR_W(32)) cu_bus();

   control_unit #(.IR_W(32), .OP_LSB(27)) dut (
      .clk   (clk),
      .reset (reset),
      .stop  (stop),
      .run   (run),
      .bus   (cu_bus.master)
   );

   always #5 clk = ~clk;

   // Bit positions of the observed word (LSB first).
   localparam logic [43:0] MConReset = 44'd1 << 0,  MHIout   = 44'd1 << 1,  MLOout  = 44'd1 << 2;
   localparam logic [43:0] MZhighout = 44'd1 << 3,  MZlowout = 44'd1 << 4,  MPCout  = 44'd1 << 5;
   localparam logic [43:0] MMDRout   = 44'd1 << 6,  MINout   = 44'd1 << 7,  MCout   = 44'd1 << 8;
   localparam logic [43:0] MRead     = 44'd1 << 9,  MRdMem   = 44'd1 << 10, MWrMem  = 44'd1 << 11;
   localparam logic [43:0] MIncPC    = 44'd1 << 12, MPCSave  = 44'd1 << 13, MAnd    = 44'd1 << 14;
   localparam logic [43:0] MOr       = 44'd1 << 15, MAdd     = 44'd1 << 16, MSub    = 44'd1 << 17;
   localparam logic [43:0] MMul      = 44'd1 << 18, MNeg     = 44'd1 << 25;
   localparam logic [43:0] MGra      = 44'd1 << 27, MGrb     = 44'd1 << 28, MGrc    = 44'd1 << 29;
   localparam logic [43:0] MRin      = 44'd1 << 30, MRout    = 44'd1 << 31, MBAout  = 44'd1 << 32;
   localparam logic [43:0] MHIin     = 44'd1 << 33, MLOin    = 44'd1 << 34, MPCin   = 44'd1 << 35;
   localparam logic [43:0] MIRin     = 44'd1 << 36, MZin     = 44'd1 << 37, MYin    = 44'd1 << 38;
   localparam logic [43:0] MMARin    = 44'd1 << 39, MMDRin   = 44'd1 << 40, MCONin  = 44'd1 << 41;
   localparam logic [43:0] MRun      = 44'd1 << 43;

   logic [43:0] obs;
   assign obs = {run, cu_bus.OUT_Portin, cu_bus.CONin, cu_bus.MDRin, cu_bus.MARin, cu_bus.Yin,
                 cu_bus.Zin, cu_bus.IRin, cu_bus.PCin, cu_bus.LOin, cu_bus.HIin, cu_bus.BAout,
                 cu_bus.Rout, cu_bus.Rin, cu_bus.Grc, cu_bus.Grb, cu_bus.Gra, cu_bus.NOT,
                 cu_bus.NEG, cu_bus.ROL, cu_bus.ROR, cu_bus.SHL, cu_bus.SHRA, cu_bus.SHR,
                 cu_bus.DIV, cu_bus.MUL, cu_bus.SUB, cu_bus.ADD, cu_bus.OR, cu_bus.AND,
                 cu_bus.PCSave, cu_bus.IncPC, cu_bus.write_mem, cu_bus.read_mem, cu_bus.Read,
                 cu_bus.Cout, cu_bus.INout, cu_bus.MDRout, cu_bus.PCout, cu_bus.Zlowout,
                 cu_bus.Zhighout, cu_bus.LOout, cu_bus.HIout, cu_bus.CON_RESET};

   task automatic check(input string tag, input logic [43:0] got, input logic [43:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare the current step, then advance one clock.
   task automatic step(input string tag, input logic [43:0] exp);
      check(tag, obs, exp);
      tick();
   endtask

   task automatic fetch(input string tag, input logic [31:0] instr);
      cu_bus.ir = instr;
      step({tag, " T0"}, MRun | MIncPC | MMARin | MPCin);
      step({tag, " T1"}, MRun | MRead | MRdMem | MMDRin);
      step({tag, " T2"}, MRun | MMDRout | MIRin);
   endtask

   initial begin
      reset = 1'b0; stop = 1'b0;
      cu_bus.ir = 32'h0; cu_bus.con_ff = 1'b0;
      tick(); tick();
      check("rst state", obs, MConReset);
      reset = 1'b1;
      tick();

      // add R1,R2,R3
      fetch("add", 32'h1891_8000);
      step("add T3", MRun | MGrb | MRout | MYin);
      step("add T4", MRun | MGrc | MRout | MAdd | MZin);
      step("add T5", MRun | MZlowout | MGra | MRin);

      fetch("sub", 32'h2000_0000);
      step("sub T3", MRun | MGrb | MRout | MYin);
      step("sub T4", MRun | MGrc | MRout | MSub | MZin);
      step("sub T5", MRun | MZlowout | MGra | MRin);

      fetch("mul", 32'h8000_0000);
      step("mul T3", MRun | MGra | MRout | MYin);
      step("mul T4", MRun | MGrb | MRout | MMul | MZin);
      step("mul T5", MRun | MZlowout | MLOin);
      step("mul T6", MRun | MZhighout | MHIin);

      fetch("ori", 32'h7000_0000);
      step("ori T3", MRun | MGrb | MRout | MYin);
      step("ori T4", MRun | MCout | MOr | MZin);
      step("ori T5", MRun | MZlowout | MGra | MRin);

      cu_bus.con_ff = 1'b0;
      fetch("br0", 32'h9800_0000);
      step("br0 T3", MRun | MGra | MRout | MCONin);
      step("br0 T4", MRun | MPCout | MYin);
      step("br0 T5", MRun | MCout | MAdd | MZin);
      step("br0 T6", MRun);

      cu_bus.con_ff = 1'b1;
      fetch("br1", 32'h9800_0000);
      step("br1 T3", MRun | MGra | MRout | MCONin);
      step("br1 T4", MRun | MPCout | MYin);
      step("br1 T5", MRun | MCout | MAdd | MZin);
      step("br1 T6", MRun | MZlowout | MPCin);
      cu_bus.con_ff = 1'b0;

      fetch("neg", 32'h8800_0000);
      step("neg T3", MRun | MGrb | MRout | MNeg | MZin);
      step("neg T4", MRun | MZlowout | MGra | MRin);

      fetch("jal", 32'hA800_0000);
      step("jal T3", MRun | MPCSave);
      step("jal T4", MRun | MGra | MRout | MPCin);

      fetch("mfhi", 32'hC000_0000);
      step("mfhi T3", MRun | MHIout | MGra | MRin);

      fetch("st", 32'h1000_0000);
      step("st T3", MRun | MGrb | MBAout | MYin);
      step("st T4", MRun | MCout | MAdd | MZin);
      step("st T5", MRun | MZlowout | MMARin);
      step("st T6", MRun | MGra | MRout | MMDRin);
      step("st T7", MRun | MWrMem);

      // nop and an undefined opcode drop straight back into fetch
      fetch("nop", 32'hD000_0000);
      fetch("undef", 32'hF800_0000);

      // ld aborted by reset during T5
      fetch("ld", 32'h0000_0000);
      step("ld T3", MRun | MGrb | MBAout | MYin);
      step("ld T4", MRun | MCout | MAdd | MZin);
      check("ld T5", obs, MRun | MZlowout | MMARin);
      reset = 1'b0;
      tick();
      check("ld abort rst", obs, MConReset);
      reset = 1'b1;
      tick();

      // stop raised mid-instruction takes effect only after the last step
      fetch("stop add", 32'h1891_8000);
      stop = 1'b1;
      step("stop add T3", MRun | MGrb | MRout | MYin);
      step("stop add T4", MRun | MGrc | MRout | MAdd | MZin);
      step("stop add T5", MRun | MZlowout | MGra | MRin);
      stop = 1'b0;
      step("stop halt 0", 44'd0);
      step("stop halt 1", 44'd0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      fetch("halt", 32'hD800_0000);
      for (int i = 0; i < 20; i++) step("halt hold", 44'd0);

      // reset wins over stop
      stop = 1'b1; reset = 1'b0;
      tick();
      check("rst over stop", obs, MConReset);
      stop = 1'b0; reset = 1'b1;
      tick();
      check("post rst T0", obs, MRun | MIncPC | MMARin | MPCin);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
